// File: rtl/blake_ctrl.sv
// Message-stream sequencer for the BLAKE2-style compression unit: pads blocks, tracks t/f,
// drives f_unit and returns the digest. Define BLAKE_CTRL_PERF_EN for blk_cnt/busy_cyc counters.
module blake_ctrl #(
    parameter int W   = 32,
    parameter int BCW = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [W*16-1:0]   msg_data,
    input  logic              msg_last,
    input  logic [BCW-1:0]    msg_bytes,
    output logic              f_dv,
    input  logic              f_drdy,
    input  logic              f_done,
    output logic [W*16-1:0]   f_m,
    output logic [W*2-1:0]    f_t,
    output logic              f_f,
    input  logic [W*8-1:0]    f_h,
    output logic              dig_valid,
    input  logic              dig_ready,
    output logic [W*8-1:0]    dig_data
`ifdef BLAKE_CTRL_PERF_EN
    ,
    output logic [31:0]       blk_cnt,
    output logic [31:0]       busy_cyc
`endif
);
    localparam int BB = 2 * W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_OUT} state_t;

    state_t            state_q, state_d;
    logic [W*16-1:0]   m_q, m_d;
    logic [W*2-1:0]    t_q, t_d;
    logic              f_q, f_d;
    logic [W*8-1:0]    h_q, h_d;
    logic [W*16-1:0]   blk;
    int                nb;

    // Valid byte count of the incoming block (clamped to BB) and its zero-padded image.
    always_comb begin
        nb = BB;
        if (msg_last && int'(msg_bytes) < BB) nb = int'(msg_bytes);
        blk = '0;
        for (int k = 0; k < BB; k++)
            blk[8*k +: 8] = (k < nb) ? msg_data[8*k +: 8] : 8'h00;
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        t_d       = t_q;
        f_d       = f_q;
        h_d       = h_q;
        msg_ready = (state_q == S_IDLE) && !rst;
        f_dv      = (state_q == S_ISSUE);
        dig_valid = (state_q == S_OUT);
        case (state_q)
            S_IDLE: if (msg_valid) begin
                m_d     = blk;
                t_d     = t_q + (2*W)'(nb);
                f_d     = msg_last;
                state_d = S_ISSUE;
            end
            S_ISSUE: if (f_drdy) state_d = S_RUN;
            S_RUN: if (f_done) begin
                h_d     = f_h;
                state_d = f_q ? S_OUT : S_IDLE;
            end
            S_OUT: if (dig_ready) begin
                t_d     = '0;
                f_d     = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            t_q     <= '0;
            f_q     <= 1'b0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            t_q     <= t_d;
            f_q     <= f_d;
            h_q     <= h_d;
        end
    end

    // m/t/f only change in IDLE or on the OUT handshake, so they are stable across ISSUE..RUN.
    assign f_m      = m_q;
    assign f_t      = t_q;
    assign f_f      = f_q;
    assign dig_data = h_q;

`ifdef BLAKE_CTRL_PERF_EN
    logic [31:0] blk_cnt_q, blk_cnt_d, busy_cyc_q, busy_cyc_d;

    always_comb begin
        blk_cnt_d  = blk_cnt_q;
        busy_cyc_d = busy_cyc_q;
        if (state_q == S_OUT && dig_ready) begin
            blk_cnt_d  = '0;
            busy_cyc_d = '0;
        end else begin
            if (f_dv && f_drdy && blk_cnt_q != '1) blk_cnt_d = blk_cnt_q + 32'd1;
            if ((state_q == S_ISSUE || state_q == S_RUN) && busy_cyc_q != '1)
                busy_cyc_d = busy_cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q  <= '0;
            busy_cyc_q <= '0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            busy_cyc_q <= busy_cyc_d;
        end
    end

    assign blk_cnt  = blk_cnt_q;
    assign busy_cyc = busy_cyc_q;
`endif
endmodule

// File: doc/blake_ctrl.md
Name: blake_ctrl

Overview:
- Message-stream sequencer for the BLAKE2-style compression unit (f_unit).
- Accepts one W*16-bit message block at a time from an upstream stream and zero-pads the final partial block.
- Maintains the running byte counter t and the final flag f, issues each block to the compression unit, and holds the block stable while that unit runs.
- Captures the compression result and presents the final digest on a valid/ready output.

Parameters:
- W, 32, word width; must equal the connected f_unit W. Block size BB = 2*W bytes.
- BCW, 7, width of msg_bytes; must satisfy 2^BCW > BB.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- msg_valid  in  1  upstream block valid
- msg_ready  out  1  upstream block accept
- msg_data  in  W*16  block; byte k in bits [8k+7:8k]
- msg_last  in  1  block is the final block of the message
- msg_bytes  in  BCW  valid bytes in the final block, 0..BB; ignored unless msg_last
- f_dv  out  1  to f_unit dv_in
- f_drdy  in  1  from f_unit drdy_out
- f_done  in  1  from f_unit dv_out, one-cycle pulse
- f_m  out  W*16  to f_unit m_in
- f_t  out  W*2  to f_unit t_in
- f_f  out  1  to f_unit f_in
- f_h  in  W*8  from f_unit h_out
- dig_valid  out  1  digest valid
- dig_ready  in  1  digest accept
- dig_data  out  W*8  digest

Behaviour:
- States:
  - IDLE: msg_ready=1. On msg_valid:
    - latch the block into m_reg, zeroing bytes at index >= msg_bytes when msg_last;
    - update t_reg: t_reg += BB if not last; t_reg += min(msg_bytes, BB) if last; wraps mod 2^(2W);
    - set f_reg = msg_last;
    - go to ISSUE.
  - ISSUE: f_dv=1. The start event is the cycle with f_dv & f_drdy; go to RUN on the following edge. f_dv stays asserted until f_drdy is seen.
  - RUN: f_dv=0. Wait for f_done. On f_done, h_reg <= f_h. Go to OUT if f_reg, else to IDLE.
  - OUT: dig_valid=1 and dig_data=h_reg. On dig_ready, go to IDLE, clear t_reg to 0 and clear f_reg to 0.
- Stability: f_m=m_reg, f_t=t_reg and f_f=f_reg are held constant from ISSUE entry through the f_done cycle. f_unit reads m_in combinationally during its rounds.
- msg_ready is 0 in ISSUE, RUN and OUT, so there is no block overlap.
- Latency:
  - accept -> f_dv high on the next cycle;
  - f_done -> dig_valid high on the next cycle for the last block;
  - f_done -> msg_ready high on the next cycle otherwise.
- f_drdy is not required high on ISSUE entry. After f_done, f_unit raises drdy one cycle later, and ISSUE absorbs that wait.
- Boundary conditions:
  - msg_bytes > BB is clamped to BB.
  - Empty message (msg_last with msg_bytes=0 on the first block) gives an all-zero block, t=0, f=1.
  - An f_done outside RUN is ignored.
  - f_drdy low while in RUN is expected and has no effect.
- Reset values:
  - state=IDLE; t_reg=0; f_reg=0; m_reg=0; h_reg=0.
  - msg_ready=0 while rst is asserted, 1 afterwards.
  - f_dv=0; dig_valid=0; dig_data=0.
  - Reset asserted mid-operation aborts immediately. f_unit shares rst, so no drain is needed.

Optional Feature:
- BLAKE_CTRL_PERF_EN defined:
  - adds output blk_cnt [31:0], blocks started since the last digest handshake; increments on the start event, clears on the OUT handshake and on reset, saturates at all-ones;
  - adds output busy_cyc [31:0], cycles spent in ISSUE or RUN, with the same clear and saturation rules.
- BLAKE_CTRL_PERF_EN undefined: both ports and their counters are absent.

Test Plan:
- Single full block, W=32: msg_last=1, msg_bytes=64, data=0x01..0x40 -> f_t=64, f_f=1, f_m equals data; dig_data equals f_h captured at f_done; dig_valid is asserted 1 cycle after f_done.
- Three blocks: last block has msg_bytes=5 -> f_t sequence 64, 128, 133; f_f=0,0,1; bytes 5..63 of the last f_m are zero; only one dig_valid occurrence.
- Empty message: msg_bytes=0 with msg_last=1 -> f_m=0, f_t=0, f_f=1, digest delivered.
- Backpressure: dig_ready held low 20 cycles -> dig_valid and dig_data stable, msg_ready=0 throughout; digest accepted on the first dig_ready cycle, next message then starts with t=0.
- f_drdy held low 7 cycles in ISSUE -> f_dv stays 1 and f_m/f_t stay stable; exactly one start event occurs. Also: msg_bytes=100 -> treated as 64.
- Reset asserted mid-RUN -> next cycle shows IDLE, f_dv=0, t_reg=0; a following message gives f_t starting at its own byte count.
